// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
package fetch_pkg;
  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: one outstanding memory request, a one-entry decode
// buffer, and redirect handling that discards wrong-path responses and buffered work.
module ifu_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              ireq_valid,
  output logic [XLEN-1:0]   ireq_addr,
  input  logic              ireq_ready,
  input  logic              iresp_valid,
  input  logic [INST_W-1:0] iresp_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              inst_ready,
  output logic              flush
);

  fetch_state_e      r_state, w_state_nxt;
  logic [XLEN-1:0]   r_pc, w_pc_nxt;
  logic [XLEN-1:0]   r_buf_pc, w_buf_pc_nxt;
  logic [INST_W-1:0] r_buf_inst, w_buf_inst_nxt;
  logic              r_kill, w_kill_nxt;
  logic              r_flush;
  logic [XLEN-1:0]   w_redirect_tgt;

  assign w_redirect_tgt = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_buf_pc   <= '0;
      r_buf_inst <= '0;
      r_kill     <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_buf_pc   <= w_buf_pc_nxt;
      r_buf_inst <= w_buf_inst_nxt;
      r_kill     <= w_kill_nxt;
      r_flush    <= redirect_valid;
    end
  end

  // A redirect always wins: it retargets pc and marks any in-flight response as stale.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_buf_pc_nxt   = r_buf_pc;
    w_buf_inst_nxt = r_buf_inst;
    w_kill_nxt     = r_kill;

    case (r_state)
      S_REQ: begin
        if (ireq_ready) begin
          w_state_nxt = S_WAIT;
          w_kill_nxt  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (iresp_valid) begin
          if (r_kill || redirect_valid) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_buf_inst_nxt = iresp_data;
            w_buf_pc_nxt   = r_pc;
            w_pc_nxt       = r_pc + 64'd4;
            w_state_nxt    = S_DRAIN;
          end
        end else if (redirect_valid) begin
          w_kill_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        if (redirect_valid || inst_ready) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase

    if (redirect_valid) begin
      w_pc_nxt = w_redirect_tgt;
    end
  end

  assign ireq_valid = (r_state == S_REQ);
  assign ireq_addr  = r_pc;
  assign inst_valid = (r_state == S_DRAIN) && !redirect_valid;
  assign inst       = r_buf_inst;
  assign inst_pc    = r_buf_pc;
  assign flush      = r_flush;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios then randomized traffic, scored against a
// model of the architectural fetch stream and a single-outstanding instruction memory.
`timescale 1ns/1ps
module tb_ifu_fetch;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        flush;

  int checks = 0;
  int failures = 0;

  // Memory model: at most one pending response, delivered a chosen number of cycles later.
  bit          memPending;
  int          memCount;
  logic [63:0] memAddr;
  bit          memNop;

  // Architectural model: the PC decode must see next, and the redirect seen last cycle.
  logic [63:0] expPc;
  bit          prevRedirect;
  int          hsCount;
  int          hsBefore;

  logic        obsIreqValid;
  logic [63:0] obsIreqAddr;
  logic        obsInstValid;
  logic [31:0] obsInst;
  logic [63:0] obsInstPc;
  logic        obsFlush;

  bit          rndRedirect;
  logic [63:0] rndTarget;

  ifu_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .ireq_ready    (ireq_ready),
    .iresp_valid   (iresp_valid),
    .iresp_data    (iresp_data),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .flush         (flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [63:0] a);
    return memNop ? 32'h0000_0013 : (a[31:0] ^ a[63:32] ^ 32'h5A5A_0003);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Called just after a falling edge: drive one cycle, score it, advance to the next fall.
  task automatic applyStimulus(input bit redir, input logic [63:0] rpc, input bit irdy,
                               input bit instRdy, input int delay);
    redirect_valid = redir;
    redirect_pc    = rpc;
    ireq_ready     = irdy;
    inst_ready     = instRdy;
    if (memPending && memCount == 0) begin
      iresp_valid = 1'b1;
      iresp_data  = memData(memAddr);
      memPending  = 1'b0;
    end else begin
      iresp_valid = 1'b0;
      iresp_data  = $urandom;
      if (memPending) memCount--;
    end
    #1;
    obsIreqValid = ireq_valid;
    obsIreqAddr  = ireq_addr;
    obsInstValid = inst_valid;
    obsInst      = inst;
    obsInstPc    = inst_pc;
    obsFlush     = flush;

    checkOutput("flush_follows_redirect", 64'(flush), 64'(prevRedirect));
    checkOutput("ireq_addr_aligned", 64'(ireq_addr[1:0]), 64'd0);
    checkOutput("req_drain_exclusive", 64'(ireq_valid & inst_valid), 64'd0);
    if (ireq_valid) checkOutput("ireq_addr_model", ireq_addr, expPc);
    if (inst_valid && instRdy) begin
      checkOutput("inst_pc_model", inst_pc, expPc);
      checkOutput("inst_model", 64'(inst), 64'(memData(expPc)));
      expPc = expPc + 64'd4;
      hsCount++;
    end
    if (redir) expPc = rpc & ~64'h3;
    if (ireq_valid && irdy) begin
      memPending = 1'b1;
      memCount   = delay - 1;
      memAddr    = ireq_addr;
    end
    prevRedirect = redir;
    @(negedge clk);
  endtask

  // Reset drops between edges so the asynchronous clear is visible before any clock.
  task automatic doReset();
    #2 rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ireq_ready     = 1'b0;
    iresp_valid    = 1'b0;
    iresp_data     = '0;
    inst_ready     = 1'b0;
    #1;
    checkOutput("rst_ireq_valid", 64'(ireq_valid), 64'd1);
    checkOutput("rst_ireq_addr", ireq_addr, RST_PC);
    checkOutput("rst_inst_valid", 64'(inst_valid), 64'd0);
    checkOutput("rst_flush", 64'(flush), 64'd0);
    checkOutput("rst_inst", 64'(inst), 64'd0);
    checkOutput("rst_inst_pc", inst_pc, 64'd0);
    memPending   = 1'b0;
    memCount     = 0;
    expPc        = RST_PC;
    prevRedirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the run completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    memNop  = 1'b1;
    hsCount = 0;
    doReset();

    // Ideal memory: three-cycle cadence starting at the reset PC.
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
      if (c == 1) checkOutput("first_req_valid", 64'(obsIreqValid), 64'd1);
      checkOutput($sformatf("ideal_valid_c%0d", c), 64'(obsInstValid), 64'(c % 3 == 0));
      if (c % 3 == 0) begin
        checkOutput("ideal_inst_pc", obsInstPc, RST_PC + 64'(4 * (c / 3 - 1)));
        checkOutput("ideal_inst", 64'(obsInst), 64'h13);
      end
    end
    memNop = 1'b0;

    // Decode backpressure holds the buffered instruction and blocks new requests.
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1);
      checkOutput("bp_inst_valid", 64'(obsInstValid), 64'd1);
      checkOutput("bp_inst_pc", obsInstPc, RST_PC + 64'd12);
      checkOutput("bp_inst", 64'(obsInst), 64'(memData(RST_PC + 64'd12)));
      checkOutput("bp_ireq_valid", 64'(obsIreqValid), 64'd0);
    end
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    checkOutput("bp_release", 64'(obsInstValid), 64'd1);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 3);
    checkOutput("bp_next_req_valid", 64'(obsIreqValid), 64'd1);
    checkOutput("bp_next_req_addr", obsIreqAddr, RST_PC + 64'd16);

    // Redirect while waiting; the response lands two cycles later and is dropped.
    applyStimulus(1'b1, 64'h0000_0000_8000_0103, 1'b1, 1'b1, 1);
    checkOutput("rw_ireq_valid", 64'(obsIreqValid), 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    checkOutput("rw_flush", 64'(obsFlush), 64'd1);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    checkOutput("rw_drop", 64'(obsInstValid), 64'd0);
    checkOutput("rw_flush_once", 64'(obsFlush), 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    checkOutput("rw_target_valid", 64'(obsIreqValid), 64'd1);
    checkOutput("rw_target_addr", obsIreqAddr, 64'h0000_0000_8000_0100);
    checkOutput("rw_no_inst", 64'(obsInstValid), 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1);
    checkOutput("rw_inst_pc", obsInstPc, 64'h0000_0000_8000_0100);

    // Redirect in drain with inst_ready high: no handshake in that cycle.
    hsBefore = hsCount;
    applyStimulus(1'b1, 64'h0000_0000_8000_2000, 1'b1, 1'b1, 1);
    checkOutput("rd_inst_valid", 64'(obsInstValid), 64'd0);
    checkOutput("rd_no_handshake", 64'(hsCount), 64'(hsBefore));

    // Redirect in the same cycle the request is accepted: that response is stale.
    applyStimulus(1'b1, 64'h0000_0000_8000_3000, 1'b1, 1'b1, 2);
    checkOutput("rd_next_addr", obsIreqAddr, 64'h0000_0000_8000_2000);
    checkOutput("rd_flush", 64'(obsFlush), 64'd1);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    checkOutput("rr_flush", 64'(obsFlush), 64'd1);
    checkOutput("rr_ireq_valid", 64'(obsIreqValid), 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    checkOutput("rr_drop", 64'(obsInstValid), 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    checkOutput("rr_req_valid", 64'(obsIreqValid), 64'd1);
    checkOutput("rr_target_addr", obsIreqAddr, 64'h0000_0000_8000_3000);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    checkOutput("rr_inst_valid", 64'(obsInstValid), 64'd1);
    checkOutput("rr_inst_pc", obsInstPc, 64'h0000_0000_8000_3000);

    // Wrap at the top of the address space; low target bits are ignored.
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    checkOutput("wrap_req_addr", obsIreqAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    checkOutput("wrap_inst_pc", obsInstPc, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 3);
    checkOutput("wrap_next_valid", 64'(obsIreqValid), 64'd1);
    checkOutput("wrap_next_addr", obsIreqAddr, 64'd0);

    // Asynchronous reset while a response is still outstanding.
    doReset();
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1);
    checkOutput("post_rst_req_addr", obsIreqAddr, RST_PC);

    // Randomized traffic scored by the stream and memory models.
    hsBefore = hsCount;
    for (int i = 0; i < 600; i++) begin
      rndRedirect = ($urandom_range(0, 9) == 0);
      rndTarget   = {$urandom, $urandom};
      applyStimulus(rndRedirect, rndTarget, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), int'($urandom_range(1, 3)));
    end
    checkOutput("random_progress", 64'(hsCount > hsBefore), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
